// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: zeroes the register bank after reset, then round-robins writeback requesters A and B onto the registered bank write port (REGBANK_ZERO_REG_EN makes register 0 hardwired zero)
module regbank_write_arbiter #(
  parameter int address_length = 3,
  parameter int data_width = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req_a_valid,
  input  logic [address_length-1:0] req_a_address,
  input  logic [data_width-1:0] req_a_data,
  output logic req_a_ready,
  input  logic req_b_valid,
  input  logic [address_length-1:0] req_b_address,
  input  logic [data_width-1:0] req_b_data,
  output logic req_b_ready,
  output logic init_done,
  output logic [address_length-1:0] write_address,
  output logic [data_width-1:0] write_data,
  output logic write_enable
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [address_length-1:0] clear_ptr;
  logic last_b;
  logic run;
  logic xfer;
  logic keep;
  logic [address_length-1:0] sel_address;
  logic [data_width-1:0] sel_data;
  always_comb begin
    run = state == RUN;
    req_a_ready = run & req_a_valid & (~req_b_valid | last_b);
    req_b_ready = run & req_b_valid & (~req_a_valid | ~last_b);
    xfer = req_a_ready | req_b_ready;
    sel_address = req_a_ready ? req_a_address : req_b_address;
    sel_data = req_a_ready ? req_a_data : req_b_data;
`ifdef REGBANK_ZERO_REG_EN
    keep = sel_address != '0;
`else
    keep = 1'b1;
`endif
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR;
      clear_ptr <= '0;
      last_b <= 1'b1;
      init_done <= 1'b0;
      write_enable <= 1'b0;
      write_address <= '0;
      write_data <= '0;
    end else if (state == CLEAR) begin
      write_enable <= 1'b1;
      write_address <= clear_ptr;
      write_data <= '0;
      clear_ptr <= clear_ptr + 1'b1;
      if (&clear_ptr) begin
        state <= RUN;
        init_done <= 1'b1;
      end
    end else begin
      write_enable <= xfer & keep;
      if (xfer) begin
        write_address <= sel_address;
        write_data <= sel_data;
        last_b <= req_b_ready;
      end
    end
  end
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: directed checks of clear sequence, round-robin grants, latency and reset abort
module tb_regbank_write_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_a_valid = 1'b0;
  logic [2:0] req_a_address = '0;
  logic [31:0] req_a_data = '0;
  logic req_a_ready;
  logic req_b_valid = 1'b0;
  logic [2:0] req_b_address = '0;
  logic [31:0] req_b_data = '0;
  logic req_b_ready;
  logic init_done;
  logic [2:0] write_address;
  logic [31:0] write_data;
  logic write_enable;
  int tests = 0;
  int errors = 0;
  regbank_write_arbiter dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_a_valid(req_a_valid),
    .req_a_address(req_a_address),
    .req_a_data(req_a_data),
    .req_a_ready(req_a_ready),
    .req_b_valid(req_b_valid),
    .req_b_address(req_b_address),
    .req_b_data(req_b_data),
    .req_b_ready(req_b_ready),
    .init_done(init_done),
    .write_address(write_address),
    .write_data(write_data),
    .write_enable(write_enable)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"}, 32'(write_enable), 32'd0);
    chk({tag, "_addr"}, 32'(write_address), 32'd0);
    chk({tag, "_data"}, write_data, 32'd0);
    chk({tag, "_init"}, 32'(init_done), 32'd0);
  endtask
  task automatic run_clear();
    req_a_valid = 1'b1;
    req_b_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("clr_rdy_a", 32'(req_a_ready), 32'd0);
      chk("clr_rdy_b", 32'(req_b_ready), 32'd0);
      tick();
      if (i == 7) begin
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
      end
      chk("clr_we", 32'(write_enable), 32'd1);
      chk("clr_addr", 32'(write_address), 32'(i));
      chk("clr_data", write_data, 32'd0);
      chk("clr_init", 32'(init_done), 32'(i == 7));
    end
    tick();
    chk("post_clr_we", 32'(write_enable), 32'd0);
    chk("post_clr_addr", 32'(write_address), 32'd7);
  endtask
  initial begin
    tick();
    tick();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    run_clear();
    req_a_address = 3'd1;
    req_a_data = 32'h11;
    req_b_address = 3'd2;
    req_b_data = 32'h22;
    req_a_valid = 1'b1;
    req_b_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_rdy_a", 32'(req_a_ready), 32'(k % 2 == 0));
      chk("rr_rdy_b", 32'(req_b_ready), 32'(k % 2 == 1));
      tick();
      chk("rr_we", 32'(write_enable), 32'd1);
      chk("rr_addr", 32'(write_address), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_data", write_data, (k % 2 == 0) ? 32'h11 : 32'h22);
    end
    req_a_valid = 1'b0;
    req_b_valid = 1'b0;
    req_a_address = 3'd5;
    req_a_data = 32'hAAAA;
    req_b_address = 3'd5;
    req_b_data = 32'hBBBB;
    req_a_valid = 1'b1;
    req_b_valid = 1'b1;
    #1;
    chk("same_rdy_a", 32'(req_a_ready), 32'd1);
    chk("same_rdy_b0", 32'(req_b_ready), 32'd0);
    tick();
    req_a_valid = 1'b0;
    chk("same_a_addr", 32'(write_address), 32'd5);
    chk("same_a_data", write_data, 32'hAAAA);
    #1;
    chk("same_rdy_b", 32'(req_b_ready), 32'd1);
    tick();
    req_b_valid = 1'b0;
    chk("same_b_we", 32'(write_enable), 32'd1);
    chk("same_b_data", write_data, 32'hBBBB);
    tick();
    chk("same_idle_we", 32'(write_enable), 32'd0);
    chk("same_final", write_data, 32'hBBBB);
    req_a_address = 3'd3;
    req_a_data = 32'hDEADBEEF;
    req_a_valid = 1'b1;
    #1;
    chk("single_rdy_a", 32'(req_a_ready), 32'd1);
    chk("single_rdy_b", 32'(req_b_ready), 32'd0);
    tick();
    req_a_valid = 1'b0;
    chk("single_we", 32'(write_enable), 32'd1);
    chk("single_addr", 32'(write_address), 32'd3);
    chk("single_data", write_data, 32'hDEADBEEF);
    tick();
    chk("single_we_off", 32'(write_enable), 32'd0);
    chk("single_hold", write_data, 32'hDEADBEEF);
    req_b_address = 3'd0;
    req_b_data = 32'h1234;
    req_b_valid = 1'b1;
    #1;
    chk("zero_rdy_b", 32'(req_b_ready), 32'd1);
    tick();
    req_b_valid = 1'b0;
`ifdef REGBANK_ZERO_REG_EN
    chk("zero_we", 32'(write_enable), 32'd0);
`else
    chk("zero_we", 32'(write_enable), 32'd1);
    chk("zero_addr", 32'(write_address), 32'd0);
    chk("zero_data", write_data, 32'h1234);
`endif
    tick();
    req_a_address = 3'd6;
    req_a_data = 32'h66;
    req_a_valid = 1'b1;
    #1;
    chk("drop_rdy_a", 32'(req_a_ready), 32'd1);
    tick();
    req_a_valid = 1'b0;
    chk("drop_we_pre", 32'(write_enable), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("drop_rst");
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_addr", 32'(write_address), 32'(i));
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort_rst");
    tick();
    reset_n = 1'b1;
    run_clear();
    tick();
    chk("replay_idle_we", 32'(write_enable), 32'd0);
    chk("replay_idle_data", write_data, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
